// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   ihit, imemload        instruction memory response (valid strobe, word)
//   stall                 decode-stage hazard hold request
//   redirect, redirect_pc taken branch/jump target from downstream
//   halt                  HALT decoded downstream
//   iREN, imemaddr        instruction read request and address (imemaddr == pc)
//   ifid_instr, ifid_npc  IF/ID latched instruction and its PC+4
//   ifid_valid            IF/ID holds a real instruction (0 = bubble)
//   fetch_count           saturating count of instructions accepted into IF/ID
//   halted                fetch stage is stopped until reset
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        iREN,
    output logic [31:0] imemaddr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic [31:0] fetch_count,
    output logic        halted
);

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    // Word-aligned throughout; wraps naturally modulo 2^32.
    assign pc_plus4 = pc + 32'd4;
    assign imemaddr = {pc[31:2], 2'b00};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        iREN       = 1'b0;
        halted     = 1'b0;
        case (state)
            FETCH: begin
                iREN = 1'b1;
                if (halt) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Datapath. Priority below reset: halt > redirect > stall > ihit.
    // In HALTED nothing is written, so every register holds.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc          <= {PC_INIT[31:2], 2'b00};
            ifid_instr  <= 32'd0;
            ifid_npc    <= 32'd0;
            ifid_valid  <= 1'b0;
            fetch_count <= 32'd0;
        end else if (state == FETCH) begin
            if (halt) begin
                ifid_instr <= 32'd0;
                ifid_npc   <= 32'd0;
                ifid_valid <= 1'b0;
            end else if (redirect) begin
                pc         <= {redirect_pc[31:2], 2'b00};
                ifid_instr <= 32'd0;
                ifid_npc   <= 32'd0;
                ifid_valid <= 1'b0;
            end else if (stall) begin
                // Hold everything; the same address is re-requested.
            end else if (ihit) begin
                ifid_instr <= imemload;
                ifid_npc   <= pc_plus4;
                ifid_valid <= 1'b1;
                pc         <= pc_plus4;
                if (fetch_count != 32'hFFFF_FFFF) begin
                    fetch_count <= fetch_count + 32'd1;
                end
            end else begin
                // Bubble: an all-zero word decodes as SLL no-op.
                ifid_instr <= 32'd0;
                ifid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;

    logic        iren_a, iren_b;
    logic [31:0] imemaddr_a, imemaddr_b;
    logic [31:0] instr_a, instr_b;
    logic [31:0] npc_a, npc_b;
    logic        valid_a, valid_b;
    logic [31:0] count_a, count_b;
    logic        halted_a, halted_b;

    int compared   = 0;
    int mismatched = 0;

    always #5 CLK = ~CLK;

    fetch_stage dut_a (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .iREN(iren_a), .imemaddr(imemaddr_a), .ifid_instr(instr_a), .ifid_npc(npc_a),
        .ifid_valid(valid_a), .fetch_count(count_a), .halted(halted_a)
    );

    fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) dut_b (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .iREN(iren_b), .imemaddr(imemaddr_b), .ifid_instr(instr_b), .ifid_npc(npc_b),
        .ifid_valid(valid_b), .fetch_count(count_b), .halted(halted_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RST = 1'b0; ihit = 1'b0; imemload = 32'd0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = 32'd0; halt = 1'b0;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                            input logic [31:0] npc, input logic valid, input logic [31:0] cnt);
        chk({tag, "_addr"},  imemaddr_a, addr);
        chk({tag, "_instr"}, instr_a, instr);
        chk({tag, "_npc"},   npc_a, npc);
        chk({tag, "_valid"}, {31'd0, valid_a}, {31'd0, valid});
        chk({tag, "_count"}, count_a, cnt);
    endtask

    initial begin
        idle();

        // Reset state
        RST = 1'b1;
        step();
        chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        chk("reset_iren", {31'd0, iren_a}, 32'd1);
        chk("reset_halted", {31'd0, halted_a}, 32'd0);
        chk("reset_b_addr", imemaddr_b, 32'hFFFF_FFFC);

        // Three back-to-back fetches
        idle();
        ihit = 1'b1; imemload = 32'h2001_0005;
        step();
        chk_ifid("f1", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 32'd1);
        chk("wrap_b_npc", npc_b, 32'h0);
        chk("wrap_b_addr", imemaddr_b, 32'h0);
        imemload = 32'h2002_0007;
        step();
        chk_ifid("f2", 32'h8, 32'h2002_0007, 32'h8, 1'b1, 32'd2);
        imemload = 32'h0022_1820;
        step();
        chk_ifid("f3", 32'hC, 32'h0022_1820, 32'hC, 1'b1, 32'd3);

        // Stall at pc=0x8 with ihit asserted
        RST = 1'b1;
        step();
        idle();
        ihit = 1'b1; imemload = 32'hAAAA_0001;
        step();
        imemload = 32'hBBBB_0002;
        step();
        chk_ifid("pre_stall", 32'h8, 32'hBBBB_0002, 32'h8, 1'b1, 32'd2);
        stall = 1'b1; imemload = 32'hDEAD_BEEF;
        step();
        chk_ifid("stall1", 32'h8, 32'hBBBB_0002, 32'h8, 1'b1, 32'd2);
        step();
        chk_ifid("stall2", 32'h8, 32'hBBBB_0002, 32'h8, 1'b1, 32'd2);
        stall = 1'b0; imemload = 32'hCCCC_0003;
        step();
        chk_ifid("post_stall", 32'hC, 32'hCCCC_0003, 32'hC, 1'b1, 32'd3);

        // No ihit: bubbles, npc holds
        idle();
        step();
        chk_ifid("bubble1", 32'hC, 32'h0, 32'hC, 1'b0, 32'd3);
        step();
        chk_ifid("bubble2", 32'hC, 32'h0, 32'hC, 1'b0, 32'd3);
        chk("bubble_iren", {31'd0, iren_a}, 32'd1);

        // Redirect beats stall and ihit; target low bits cleared
        redirect = 1'b1; redirect_pc = 32'h0000_0103; stall = 1'b1;
        ihit = 1'b1; imemload = 32'h1234_5678;
        step();
        chk_ifid("redirect", 32'h100, 32'h0, 32'h0, 1'b0, 32'd3);
        idle();
        ihit = 1'b1; imemload = 32'h0800_0040;
        step();
        chk_ifid("after_redir", 32'h104, 32'h0800_0040, 32'h104, 1'b1, 32'd4);

        // Halt together with redirect
        halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; imemload = 32'h5555_5555;
        step();
        chk_ifid("halt", 32'h104, 32'h0, 32'h0, 1'b0, 32'd4);
        chk("halt_iren", {31'd0, iren_a}, 32'd0);
        chk("halt_halted", {31'd0, halted_a}, 32'd1);
        halt = 1'b0;
        step();
        step();
        chk_ifid("halted_hold", 32'h104, 32'h0, 32'h0, 1'b0, 32'd4);
        chk("halted_iren", {31'd0, iren_a}, 32'd0);

        // Reset leaves HALTED
        RST = 1'b1;
        step();
        chk_ifid("halt_reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        chk("halt_reset_iren", {31'd0, iren_a}, 32'd1);
        chk("halt_reset_halted", {31'd0, halted_a}, 32'd0);

        // Reset during a stall with a word held in IF/ID
        idle();
        ihit = 1'b1; imemload = 32'h7777_0007;
        step();
        stall = 1'b1; RST = 1'b1;
        step();
        chk_ifid("stall_reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        idle();
        step();
        chk("stall_reset_iren", {31'd0, iren_a}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_INIT, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  one clock; reset is synchronous and active-high.
REQ-004 ihit  in  1  instruction memory returns imemload valid this cycle.
REQ-005 imemload  in  32  instruction word from instruction memory.
REQ-006 stall  in  1  hazard hold request from the downstream decode stage.
REQ-007 redirect  in  1  downstream resolved a taken branch, jump, JAL or JR this cycle.
REQ-008 redirect_pc  in  32  target PC for redirect.
REQ-009 halt  in  1  HALT decoded downstream.
REQ-010 iREN  out  1  instruction read request.
REQ-011 imemaddr  out  32  instruction fetch address; always equals pc.
REQ-012 ifid_instr  out  32  latched instruction; [31:26] drives the control unit opcode, [5:0] drives funct.
REQ-013 ifid_npc  out  32  latched PC+4 of ifid_instr, used for the REGSRC_NPC/JAL link and branch offsets.
REQ-014 ifid_valid  out  1  ifid_instr holds a real instruction (0 = bubble).
REQ-015 fetch_count  out  32  number of instructions accepted into IF/ID since reset.
REQ-016 halted  out  1  fetch stage is in HALTED state.

Function
REQ-017 States SHALL be FETCH and HALTED only; the reset state SHALL be FETCH.
REQ-018 iREN SHALL be 1 in FETCH and 0 in HALTED.
REQ-019 Event priority each cycle SHALL be: RST > halt > redirect > stall > ihit.
REQ-020 halt in FETCH: go to HALTED next cycle; pc holds; IF/ID flushed (valid=0, instr=0, npc=0); any ihit that cycle is discarded.
REQ-021 HALTED SHALL be left only by RST; in HALTED all inputs except RST are ignored and all registers hold.
REQ-022 redirect, no halt: pc <= {redirect_pc[31:2],2'b00}; IF/ID flushed; ihit that cycle discarded; fetch_count unchanged.
REQ-023 redirect overrides stall in the same cycle.
REQ-024 stall, no redirect/halt: pc, IF/ID and fetch_count hold; any ihit that cycle is discarded and the same address is re-requested.
REQ-025 ihit, no stall/redirect/halt: ifid_instr <= imemload; ifid_npc <= pc+4; ifid_valid <= 1; pc <= pc+4; fetch_count +1.
REQ-026 No ihit, no stall/redirect/halt: pc holds; ifid_valid <= 0 and ifid_instr <= 0 (bubble, decodes as SLL no-op); ifid_npc holds.
REQ-027 Fetch latency: one instruction accepted per cycle while ihit=1 continuously; IF/ID outputs are visible the cycle after acceptance.
REQ-028 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-029 fetch_count SHALL saturate at 32'hFFFF_FFFF.
REQ-030 imemaddr SHALL be combinationally equal to pc with bits [1:0] always 0.

Reset
REQ-031 RST=1 at an edge: pc <= PC_INIT; ifid_instr, ifid_npc, ifid_valid, fetch_count <= 0; state <= FETCH.
REQ-032 RST asserted mid-stall, mid-redirect or in HALTED SHALL produce the same reset state; iREN=1 in the first cycle after RST deasserts.

Verification
REQ-033 Reset then ihit=1 for 3 cycles with imemload 0x2001_0005, 0x2002_0007, 0x0022_1820 -> imemaddr 0,4,8,12; ifid_npc 4,8,12; fetch_count 3.
REQ-034 ihit=1 with stall=1 for 2 cycles at pc=0x8 -> pc stays 0x8, IF/ID unchanged, fetch_count unchanged; stall release then ihit -> accepts the word at 0x8.
REQ-035 redirect=1, redirect_pc=0x0000_0103, stall=1, ihit=1 -> next pc=0x100, ifid_valid=0, ifid_instr=0, fetch_count unchanged.
REQ-036 halt=1 together with redirect=1 -> HALTED, iREN=0, pc unchanged, ifid_valid=0; later ihit/redirect ignored; RST -> pc=PC_INIT, iREN=1.
REQ-037 PC_INIT=32'hFFFF_FFFC, one ihit -> ifid_npc=0, pc=0.
REQ-038 ihit=0 for 2 cycles during FETCH -> ifid_valid=0, ifid_instr=0, pc holds, iREN stays 1.
